// File: rtl/sme_input_sequencer.sv
// sme_input_sequencer: buffers a framed string record and pattern records
// from a byte stream, replays string then pattern to the matching engine,
// waits for the engine result (with timeout) and holds it on a valid/ready
// result port. All outputs are registered from next-state values.
module sme_input_sequencer #(
    parameter int unsigned STR_MAX     = 32,
    parameter int unsigned PAT_MAX     = 8,
    parameter int unsigned TIMEOUT_CYC = 1023,
    parameter int unsigned GAP_CYC     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       in_is_pat,
    output logic [7:0] eng_chardata,
    output logic       eng_isstring,
    output logic       eng_ispattern,
    input  logic       eng_valid,
    input  logic       eng_match,
    input  logic [4:0] eng_match_index,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       res_err,
    output logic       res_timeout
);

    localparam int unsigned STR_AW = (STR_MAX > 1) ? $clog2(STR_MAX) : 1;
    localparam int unsigned STR_LW = $clog2(STR_MAX + 1);
    localparam int unsigned PAT_AW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
    localparam int unsigned PAT_LW = $clog2(PAT_MAX + 1);
    localparam int unsigned WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int unsigned GAP_W  = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

    localparam logic [STR_LW-1:0] STR_MAX_L = STR_LW'(STR_MAX);
    localparam logic [STR_LW-1:0] STR_ONE   = STR_LW'(1);
    localparam logic [PAT_LW-1:0] PAT_MAX_L = PAT_LW'(PAT_MAX);
    localparam logic [PAT_LW-1:0] PAT_ONE   = PAT_LW'(1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] TO_LAST   = WAIT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [2:0] {
        IDLE, LOAD_STR, LOAD_PAT, PLAY_STR, PLAY_PAT, GAP, WAIT_ENG, HOLD_RES
    } state_t;

    state_t state_q, state_d;

    logic [7:0] str_buf_q [STR_MAX];
    logic [7:0] pat_buf_q [PAT_MAX];

    logic [STR_LW-1:0] str_len_q, str_len_d;
    logic [PAT_LW-1:0] pat_len_q, pat_len_d;
    logic              str_trunc_q, str_trunc_d;
    logic              pat_trunc_q, pat_trunc_d;
    logic              str_stored_q, str_stored_d;
    logic [STR_LW-1:0] sidx_q, sidx_d;
    logic [PAT_LW-1:0] pidx_q, pidx_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic              in_ready_q, in_ready_d;
    logic [7:0]        eng_chardata_q, eng_chardata_d;
    logic              eng_isstring_q, eng_isstring_d;
    logic              eng_ispattern_q, eng_ispattern_d;
    logic              res_valid_q, res_valid_d;
    logic              res_match_q, res_match_d;
    logic [4:0]        res_index_q, res_index_d;
    logic              res_err_q, res_err_d;
    logic              res_timeout_q, res_timeout_d;

    logic              accept;
    logic              pat_end;
    logic              str_we;
    logic [STR_AW-1:0] str_wa;
    logic              pat_we;
    logic [PAT_AW-1:0] pat_wa;

    assign accept = in_valid && in_ready_q;

    // Next-state, buffer write control and result capture.
    always_comb begin
        state_d      = state_q;
        str_len_d    = str_len_q;
        pat_len_d    = pat_len_q;
        str_trunc_d  = str_trunc_q;
        pat_trunc_d  = pat_trunc_q;
        str_stored_d = str_stored_q;
        sidx_d       = sidx_q;
        pidx_d       = pidx_q;
        gap_d        = gap_q;
        wait_d       = wait_q;
        res_match_d  = res_match_q;
        res_index_d  = res_index_q;
        res_err_d    = res_err_q;
        res_timeout_d = res_timeout_q;
        str_we       = 1'b0;
        str_wa       = '0;
        pat_we       = 1'b0;
        pat_wa       = '0;
        pat_end      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!in_is_pat) begin
                        str_we       = 1'b1;
                        str_len_d    = STR_ONE;
                        str_trunc_d  = 1'b0;
                        str_stored_d = 1'b0;
                        state_d      = LOAD_STR;
                        if (in_last) begin
                            str_stored_d = 1'b1;
                            state_d      = IDLE;
                        end
                    end else begin
                        pat_we      = 1'b1;
                        pat_len_d   = PAT_ONE;
                        pat_trunc_d = 1'b0;
                        state_d     = LOAD_PAT;
                        pat_end     = in_last;
                    end
                end
            end
            LOAD_STR: begin
                if (accept) begin
                    if (str_len_q < STR_MAX_L) begin
                        str_we    = 1'b1;
                        str_wa    = str_len_q[STR_AW-1:0];
                        str_len_d = str_len_q + STR_ONE;
                    end else begin
                        str_trunc_d = 1'b1;
                    end
                    if (in_last) begin
                        str_stored_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            LOAD_PAT: begin
                if (accept) begin
                    if (pat_len_q < PAT_MAX_L) begin
                        pat_we    = 1'b1;
                        pat_wa    = pat_len_q[PAT_AW-1:0];
                        pat_len_d = pat_len_q + PAT_ONE;
                    end else begin
                        pat_trunc_d = 1'b1;
                    end
                    pat_end = in_last;
                end
            end
            PLAY_STR: begin
                if (sidx_q == str_len_q - STR_ONE) begin
                    state_d = PLAY_PAT;
                    pidx_d  = '0;
                end else begin
                    sidx_d = sidx_q + STR_ONE;
                end
            end
            PLAY_PAT: begin
                if (pidx_q == pat_len_q - PAT_ONE) begin
                    if (GAP_CYC == 0) begin
                        state_d = WAIT_ENG;
                        wait_d  = '0;
                    end else begin
                        state_d = GAP;
                        gap_d   = '0;
                    end
                end else begin
                    pidx_d = pidx_q + PAT_ONE;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = WAIT_ENG;
                    wait_d  = '0;
                end else begin
                    gap_d = gap_q + GAP_ONE;
                end
            end
            WAIT_ENG: begin
                // eng_valid is checked first so it wins over a same-cycle timeout.
                if (eng_valid) begin
                    state_d       = HOLD_RES;
                    res_match_d   = eng_match;
                    res_index_d   = eng_match ? eng_match_index : 5'd0;
                    res_err_d     = str_trunc_q | pat_trunc_q;
                    res_timeout_d = 1'b0;
                end else if (wait_q == TO_LAST) begin
                    state_d       = HOLD_RES;
                    res_match_d   = 1'b0;
                    res_index_d   = 5'd0;
                    res_err_d     = str_trunc_q | pat_trunc_q;
                    res_timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            HOLD_RES: begin
                if (res_ready) begin
                    state_d       = IDLE;
                    res_match_d   = 1'b0;
                    res_index_d   = 5'd0;
                    res_err_d     = 1'b0;
                    res_timeout_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Final pattern beat, whether it arrived in IDLE or LOAD_PAT.
        if (pat_end) begin
            if (!str_stored_q) begin
                state_d       = HOLD_RES;
                res_match_d   = 1'b0;
                res_index_d   = 5'd0;
                res_err_d     = 1'b1;
                res_timeout_d = 1'b0;
            end else begin
                state_d = PLAY_STR;
                sidx_d  = '0;
            end
        end
    end

    // Output values decoded from the next state so the registered outputs track the state register.
    always_comb begin
        in_ready_d      = (state_d == IDLE) || (state_d == LOAD_STR) || (state_d == LOAD_PAT);
        eng_isstring_d  = (state_d == PLAY_STR);
        eng_ispattern_d = (state_d == PLAY_PAT);
        res_valid_d     = (state_d == HOLD_RES);
        eng_chardata_d  = '0;
        if (state_d == PLAY_STR) begin
            eng_chardata_d = str_buf_q[sidx_d[STR_AW-1:0]];
        end else if (state_d == PLAY_PAT) begin
            eng_chardata_d = pat_buf_q[pidx_d[PAT_AW-1:0]];
        end
    end

    // State, counters, flags and registered outputs with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            str_len_q       <= '0;
            pat_len_q       <= '0;
            str_trunc_q     <= 1'b0;
            pat_trunc_q     <= 1'b0;
            str_stored_q    <= 1'b0;
            sidx_q          <= '0;
            pidx_q          <= '0;
            gap_q           <= '0;
            wait_q          <= '0;
            in_ready_q      <= 1'b0;
            eng_chardata_q  <= '0;
            eng_isstring_q  <= 1'b0;
            eng_ispattern_q <= 1'b0;
            res_valid_q     <= 1'b0;
            res_match_q     <= 1'b0;
            res_index_q     <= '0;
            res_err_q       <= 1'b0;
            res_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            str_len_q       <= str_len_d;
            pat_len_q       <= pat_len_d;
            str_trunc_q     <= str_trunc_d;
            pat_trunc_q     <= pat_trunc_d;
            str_stored_q    <= str_stored_d;
            sidx_q          <= sidx_d;
            pidx_q          <= pidx_d;
            gap_q           <= gap_d;
            wait_q          <= wait_d;
            in_ready_q      <= in_ready_d;
            eng_chardata_q  <= eng_chardata_d;
            eng_isstring_q  <= eng_isstring_d;
            eng_ispattern_q <= eng_ispattern_d;
            res_valid_q     <= res_valid_d;
            res_match_q     <= res_match_d;
            res_index_q     <= res_index_d;
            res_err_q       <= res_err_d;
            res_timeout_q   <= res_timeout_d;
        end
    end

    // Record buffers; contents are only meaningful up to the stored lengths.
    always_ff @(posedge clk) begin
        if (str_we) str_buf_q[str_wa] <= in_data;
        if (pat_we) pat_buf_q[pat_wa] <= in_data;
    end

    assign in_ready      = in_ready_q;
    assign eng_chardata  = eng_chardata_q;
    assign eng_isstring  = eng_isstring_q;
    assign eng_ispattern = eng_ispattern_q;
    assign res_valid     = res_valid_q;
    assign res_match     = res_match_q;
    assign res_index     = res_index_q;
    assign res_err       = res_err_q;
    assign res_timeout   = res_timeout_q;

endmodule

// File: tb/tb_sme_input_sequencer.sv
// Directed bench for sme_input_sequencer with a hand-driven engine.
module tb_sme_input_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_is_pat;
    logic [7:0] eng_chardata;
    logic       eng_isstring;
    logic       eng_ispattern;
    logic       eng_valid;
    logic       eng_match;
    logic [4:0] eng_match_index;
    logic       res_valid;
    logic       res_ready;
    logic       res_match;
    logic [4:0] res_index;
    logic       res_err;
    logic       res_timeout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sme_input_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_last         (in_last),
        .in_is_pat       (in_is_pat),
        .eng_chardata    (eng_chardata),
        .eng_isstring    (eng_isstring),
        .eng_ispattern   (eng_ispattern),
        .eng_valid       (eng_valid),
        .eng_match       (eng_match),
        .eng_match_index (eng_match_index),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_match       (res_match),
        .res_index       (res_index),
        .res_err         (res_err),
        .res_timeout     (res_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input logic is_pat);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        in_is_pat = is_pat;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_is_pat = 1'b0;
        in_data   = 8'h00;
    endtask

    task automatic send_rec(input string s, input logic is_pat);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], (i == s.len() - 1), is_pat);
    endtask

    // Called right after the last pattern byte is accepted; ends just after WAIT_ENG entry.
    task automatic chk_replay(input string s, input string p);
        for (int i = 0; i < s.len(); i++) begin
            chk("play_str", {21'b0, in_ready, eng_isstring, eng_ispattern, eng_chardata},
                {21'b0, 1'b0, 1'b1, 1'b0, s[i]});
            tick();
        end
        for (int i = 0; i < p.len(); i++) begin
            chk("play_pat", {21'b0, in_ready, eng_isstring, eng_ispattern, eng_chardata},
                {21'b0, 1'b0, 1'b0, 1'b1, p[i]});
            tick();
        end
        chk("gap", {21'b0, in_ready, eng_isstring, eng_ispattern, eng_chardata}, 32'd0);
        tick();
    endtask

    task automatic respond(input logic m, input logic [4:0] idx);
        eng_valid       = 1'b1;
        eng_match       = m;
        eng_match_index = idx;
        tick();
        eng_valid       = 1'b0;
        eng_match       = 1'b0;
        eng_match_index = 5'd0;
    endtask

    task automatic chk_res(input string tag, input logic m, input logic [4:0] idx,
                           input logic e, input logic to);
        chk(tag, {23'b0, res_valid, res_match, res_index, res_err, res_timeout},
            {23'b0, 1'b1, m, idx, e, to});
    endtask

    task automatic ack(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk(tag, {30'b0, res_valid, in_ready}, {30'b0, 1'b0, 1'b1});
    endtask

    initial begin
        int    n;
        logic  seen;
        string s40;

        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; in_is_pat = 1'b0;
        eng_valid = 1'b0; eng_match = 1'b0; eng_match_index = 5'd0; res_ready = 1'b0;
        tick();
        tick();
        chk("reset_outs", {12'b0, in_ready, eng_isstring, eng_ispattern, eng_chardata,
                           res_valid, res_match, res_index, res_err, res_timeout}, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_ready", 32'(in_ready), 32'd1);

        // Pattern with no stored string
        send_byte(8'h78, 1'b1, 1'b1);
        n = 0;
        seen = 1'b0;
        while (res_valid !== 1'b1 && n < 4) begin
            seen = seen | eng_isstring | eng_ispattern;
            tick();
            n++;
        end
        chk("nostr_latency", 32'(n <= 1), 32'd1);
        chk_res("nostr_res", 1'b0, 5'd0, 1'b1, 1'b0);
        seen = seen | eng_isstring | eng_ispattern;
        tick();
        seen = seen | eng_isstring | eng_ispattern;
        chk_res("nostr_hold", 1'b0, 5'd0, 1'b1, 1'b0);
        chk("nostr_no_strobe", 32'(seen), 32'd0);
        ack("nostr_ack");

        // String "ab cd" then pattern "cd"
        send_rec("ab cd", 1'b0);
        chk("str_load_idle", {29'b0, in_ready, eng_isstring, eng_ispattern}, {29'b0, 3'b100});
        eng_valid = 1'b1; eng_match = 1'b1; eng_match_index = 5'd4;
        tick();
        eng_valid = 1'b0; eng_match = 1'b0; eng_match_index = 5'd0;
        chk("idle_engvalid_ignored", {30'b0, res_valid, in_ready}, {30'b0, 2'b01});
        send_rec("cd", 1'b1);
        chk_replay("ab cd", "cd");
        respond(1'b1, 5'd3);
        chk_res("match_cd", 1'b1, 5'd3, 1'b0, 1'b0);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk_res("match_cd_hold", 1'b1, 5'd3, 1'b0, 1'b0);
        ack("match_cd_ack");

        // Second pattern reuses the stored string; no-match forces index 0
        send_rec("zz", 1'b1);
        chk_replay("ab cd", "zz");
        respond(1'b0, 5'd7);
        chk_res("nomatch_idx0", 1'b0, 5'd0, 1'b0, 1'b0);
        ack("nomatch_ack");

        // 40-byte string is truncated to 32
        s40 = "";
        for (int i = 0; i < 40; i++) s40 = $sformatf("%s%c", s40, 65 + (i % 26));
        send_rec(s40, 1'b0);
        send_rec("Q", 1'b1);
        chk_replay(s40.substr(0, 31), "Q");
        respond(1'b1, 5'd5);
        chk_res("trunc_err", 1'b1, 5'd5, 1'b1, 1'b0);
        ack("trunc_ack");

        // Engine never answers
        send_rec("hello", 1'b0);
        send_rec("lo", 1'b1);
        chk_replay("hello", "lo");
        n = 0;
        while (res_valid !== 1'b1 && n < 1100) begin
            tick();
            n++;
        end
        chk("timeout_cycles", n, 32'd1023);
        chk_res("timeout_res", 1'b0, 5'd0, 1'b0, 1'b1);
        ack("timeout_ack");

        // eng_valid in the timeout cycle wins
        send_rec("he", 1'b1);
        chk_replay("hello", "he");
        for (int i = 0; i < 1022; i++) tick();
        chk("tie_pre", 32'(res_valid), 32'd0);
        respond(1'b1, 5'd9);
        chk_res("tie_engwins", 1'b1, 5'd9, 1'b0, 1'b0);
        ack("tie_ack");

        // Reset in the middle of string replay
        send_rec("lo", 1'b1);
        chk("rst_play_start", {23'b0, eng_isstring, eng_chardata}, {23'b0, 1'b1, 8'h68});
        tick();
        tick();
        #1 reset = 1'b1;
        #1;
        chk("rst_async_outs", {12'b0, in_ready, eng_isstring, eng_ispattern, eng_chardata,
                               res_valid, res_match, res_index, res_err, res_timeout}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("rst_release_ready", 32'(in_ready), 32'd1);
        send_byte(8'h78, 1'b1, 1'b1);
        n = 0;
        while (res_valid !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        chk_res("rst_nostr_err", 1'b0, 5'd0, 1'b1, 1'b0);
        ack("rst_ack");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
